// File: rtl/bounce_emulator.sv
// Switch-bounce emulator: turns a clean level change into a burst of
// toggles that always ends on the new level, then holds it stable for a
// settle window before the next change is accepted.
module bounce_emulator #(
  parameter int          RANDOM     = 1,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MIN_GAP    = 4,
  parameter int          GAP_RAND_W = 4,
  parameter int          FIX_K      = 2,
  parameter int          SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clean,
  input  logic enable,
  output logic noisy,
  output logic busy,
  output logic bounce_done
);

  // Gap counter holds (gap - 1), so it must reach MIN_GAP + 2^GAP_RAND_W - 2;
  // sizing for the full gap value leaves comfortable headroom.
  localparam int GAP_MAX = MIN_GAP + (2 ** GAP_RAND_W) - 1;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic               level_q;
  logic               target;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_load;
  logic [2:0]         tog_cnt;
  logic [2:0]         tog_load;
  logic [SET_W-1:0]   set_cnt;

  // Fibonacci feedback from taps 16,14,13,11.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running LFSR, advances every cycle regardless of state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Next gap (stored as gap - 1) and remaining toggle count after the first
  // toggle (2k - 2), selected by the RANDOM mode.
  always_comb begin
    gap_load = GAP_W'(MIN_GAP - 1);
    tog_load = 3'(2 * FIX_K - 2);
    if (RANDOM != 0) begin
      gap_load = GAP_W'(MIN_GAP - 1) + GAP_W'(lfsr[GAP_RAND_W-1:0]);
      tog_load = {lfsr[1:0], 1'b0};
    end
  end

  // Sequence FSM with registered noisy/busy/bounce_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      noisy       <= 1'b0;
      level_q     <= 1'b0;
      target      <= 1'b0;
      busy        <= 1'b0;
      bounce_done <= 1'b0;
      gap_cnt     <= '0;
      tog_cnt     <= '0;
      set_cnt     <= '0;
    end else begin
      bounce_done <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        noisy   <= clean;
        level_q <= clean;
        busy    <= 1'b0;
        gap_cnt <= '0;
        tog_cnt <= '0;
        set_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
            if (clean != level_q) begin
              target  <= clean;
              noisy   <= clean;
              busy    <= 1'b1;
              tog_cnt <= tog_load;
              gap_cnt <= gap_load;
              // A single-toggle sequence (k = 1) is already on target.
              if (tog_load == '0) begin
                state   <= SETTLE;
                set_cnt <= SET_W'(SETTLE_CYC - 1);
              end else begin
                state   <= BOUNCE;
              end
            end
          end
          BOUNCE: begin
            if (gap_cnt == '0) begin
              noisy   <= ~noisy;
              tog_cnt <= tog_cnt - 3'd1;
              if (tog_cnt == 3'd1) begin
                noisy   <= target;
                state   <= SETTLE;
                set_cnt <= SET_W'(SETTLE_CYC - 1);
              end else begin
                gap_cnt <= gap_load;
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          SETTLE: begin
            if (set_cnt == '0) begin
              state       <= IDLE;
              level_q     <= target;
              busy        <= 1'b0;
              bounce_done <= 1'b1;
            end else begin
              set_cnt <= set_cnt - SET_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: a fixed-pattern instance checked every cycle
// against a time-offset model plus literal waveform points, and a
// randomised instance checked against the statistical envelope rules.
module tb_bounce_emulator;

  localparam int MIN_GAP    = 4;
  localparam int FIX_K      = 2;
  localparam int SETTLE_CYC = 16;
  localparam int LAST_D     = (2 * FIX_K - 2) * MIN_GAP;
  localparam int END_D      = LAST_D + SETTLE_CYC;
  localparam int N_EDGES    = 200;

  logic clk = 1'b0;
  logic reset_n, clean, enable;
  logic noisy, busy, bounce_done;
  logic reset_n_r, clean_r;
  logic noisy_r, busy_r, done_r;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bounce_emulator #(
    .RANDOM(0), .SEED(16'hACE1), .MIN_GAP(MIN_GAP), .GAP_RAND_W(4),
    .FIX_K(FIX_K), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clean(clean), .enable(enable),
    .noisy(noisy), .busy(busy), .bounce_done(bounce_done)
  );

  bounce_emulator #(
    .RANDOM(1), .SEED(16'hACE1), .MIN_GAP(MIN_GAP), .GAP_RAND_W(4),
    .FIX_K(FIX_K), .SETTLE_CYC(SETTLE_CYC)
  ) dut_r (
    .clk(clk), .reset_n(reset_n_r), .clean(clean_r), .enable(1'b1),
    .noisy(noisy_r), .busy(busy_r), .bounce_done(done_r)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a sequence is described by its start edge and target; outputs
  // are derived from the edge offset since start.
  logic m_active, m_level, m_target;
  int   m_n, m_start, d;
  logic exp_noisy, exp_busy, exp_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_level = 1'b0; m_target = 1'b0;
      exp_noisy = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      m_n = m_n + 1;
      exp_done = 1'b0;
      if (!enable) begin
        m_active = 1'b0; m_level = clean;
        exp_noisy = clean; exp_busy = 1'b0;
      end else if (m_active) begin
        d = m_n - m_start;
        if (d == END_D) begin
          m_active = 1'b0; m_level = m_target;
          exp_done = 1'b1; exp_busy = 1'b0; exp_noisy = m_target;
        end else begin
          exp_busy = 1'b1;
          if (d >= LAST_D || ((d / MIN_GAP) % 2 == 0)) exp_noisy = m_target;
          else exp_noisy = ~m_target;
        end
      end else if (clean != m_level) begin
        m_active = 1'b1; m_start = m_n; m_target = clean;
        exp_noisy = clean; exp_busy = 1'b1;
      end else begin
        exp_noisy = m_level; exp_busy = 1'b0;
      end
    end
  end

  initial m_n = 0;

  // Every-cycle comparison of the fixed-pattern instance against the model.
  always @(negedge clk) begin
    chk1("model_noisy", noisy, exp_noisy);
    chk1("model_busy", busy, exp_busy);
    chk1("model_done", bounce_done, exp_done);
  end

  // Envelope monitor for the randomised instance.
  logic rnd_on = 1'b0;
  logic prev_r;
  logic in_seq = 1'b0;
  int   toggles = 0;
  int   last_tog = 0;
  int   seqs = 0;
  int   gap;

  always @(negedge clk) begin
    if (rnd_on) begin
      if (noisy_r != prev_r) begin
        if (!in_seq) begin
          in_seq = 1'b1;
          toggles = 1;
        end else begin
          toggles++;
          gap = cyc - last_tog;
          chk1("rand_gap_range", (gap >= MIN_GAP) && (gap <= MIN_GAP + 15), 1'b1);
        end
        last_tog = cyc;
      end
      if (done_r) begin
        chk1("rand_toggle_count", (toggles % 2 == 1) && (toggles <= 7), 1'b1);
        chk1("rand_final_level", noisy_r, clean_r);
        seqs++;
        in_seq = 1'b0;
        toggles = 0;
      end
      prev_r = noisy_r;
    end
  end

  initial begin
    reset_n = 1'b0; clean = 1'b0; enable = 1'b1;
    reset_n_r = 1'b0; clean_r = 1'b0;
    repeat (3) step();
    chk1("reset_noisy", noisy, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", bounce_done, 1'b0);
    reset_n = 1'b1; reset_n_r = 1'b1;
    repeat (3) step();

    // Rising edge: 1 at T, 0 at T+4, 1 at T+8, done after T+24.
    clean = 1'b1;
    for (int j = 0; j <= 26; j++) begin
      step();
      if (j == 0) begin chk1("rise_t0_noisy", noisy, 1'b1); chk1("rise_t0_busy", busy, 1'b1); end
      if (j == 3) chk1("rise_t3_noisy", noisy, 1'b1);
      if (j == 4) chk1("rise_t4_noisy", noisy, 1'b0);
      if (j == 7) chk1("rise_t7_noisy", noisy, 1'b0);
      if (j == 8) chk1("rise_t8_noisy", noisy, 1'b1);
      if (j == 23) begin chk1("rise_t23_busy", busy, 1'b1); chk1("rise_t23_done", bounce_done, 1'b0); end
      if (j == 24) begin chk1("rise_t24_busy", busy, 1'b0); chk1("rise_t24_done", bounce_done, 1'b1); end
      if (j == 25) chk1("rise_t25_done", bounce_done, 1'b0);
    end

    // Falling edge mirrors the pattern.
    clean = 1'b0;
    for (int j = 0; j <= 26; j++) begin
      step();
      if (j == 0) chk1("fall_t0_noisy", noisy, 1'b0);
      if (j == 4) chk1("fall_t4_noisy", noisy, 1'b1);
      if (j == 8) chk1("fall_t8_noisy", noisy, 1'b0);
      if (j == 24) begin chk1("fall_t24_done", bounce_done, 1'b1); chk1("fall_t24_noisy", noisy, 1'b0); end
    end

    // Clean returns low mid-bounce: first sequence completes, second follows.
    clean = 1'b1;
    for (int j = 0; j <= 52; j++) begin
      step();
      if (j == 5) clean = 1'b0;
      if (j == 24) begin chk1("retgt_t24_done", bounce_done, 1'b1); chk1("retgt_t24_noisy", noisy, 1'b1); end
      if (j == 25) begin chk1("retgt_t25_busy", busy, 1'b1); chk1("retgt_t25_noisy", noisy, 1'b0); end
      if (j == 49) chk1("retgt_t49_done", bounce_done, 1'b1);
    end

    // Enable dropped mid-sequence: passthrough takes over.
    clean = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      step();
      if (j == 4) enable = 1'b0;
      if (j == 5) begin
        chk1("dis_busy", busy, 1'b0);
        chk1("dis_noisy", noisy, 1'b1);
        chk1("dis_done", bounce_done, 1'b0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      clean = ~clean;
      step();
      chk1("pass_noisy", noisy, clean);
    end
    enable = 1'b1;
    repeat (3) step();
    chk1("reen_busy", busy, 1'b0);

    // Reset mid-sequence aborts; a new sequence starts right after release.
    clean = 1'b0;
    for (int j = 0; j <= 6; j++) step();
    chk1("prerst_noisy", noisy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("rst_noisy", noisy, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", bounce_done, 1'b0);
    clean = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk1("postrst_noisy", noisy, 1'b1);
    chk1("postrst_busy", busy, 1'b1);
    repeat (30) step();

    // Randomised instance: alternating clean edges spaced wider than the
    // longest possible sequence (6 * 19 + 16 cycles).
    prev_r = noisy_r;
    rnd_on = 1'b1;
    for (int e = 0; e < N_EDGES; e++) begin
      clean_r = ~clean_r;
      repeat (150) step();
    end
    chki("rand_sequences", seqs, N_EDGES);
    chk1("rand_idle_end", busy_r, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
